// File: rtl/csa_resolve_seq_if.sv
// csa_resolve_seq_if: operand/result handshake bundle between the CSA,
// the chunked carry-propagate stage and the downstream normaliser.
// master = upstream/consumer side, slave = csa_resolve_seq.
interface csa_resolve_seq_if #(
  parameter int N = 12
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] s_in;
  logic [N-1:0] t_in;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   sum;
  logic         busy;

  modport master (
    output in_valid, s_in, t_in, out_ready,
    input  in_ready, out_valid, sum, busy
  );

  modport slave (
    input  in_valid, s_in, t_in, out_ready,
    output in_ready, out_valid, sum, busy
  );
endinterface

// File: rtl/csa_resolve_seq.sv
// csa_resolve_seq: resolves the CSA sum/carry vectors into one binary
// result, CHUNK bits per cycle, with a registered inter-chunk carry.
// Optional build macro CSA_RESOLVE_EARLY_EXIT_EN: leave RUN as soon as the
// remaining operand bits are zero and no carry is pending.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | resolving chunk r_idx each cycle
// DONE  | result valid, held until out_ready
module csa_resolve_seq #(
  parameter int N     = 12,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  csa_resolve_seq_if.slave   bus
);

  localparam int NCH   = (N + CHUNK - 1) / CHUNK;
  localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RW    = N + 1;
  // position of the true carry-out inside the last chunk's adder result
  localparam int LASTB = N - (NCH - 1) * CHUNK;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_s;
  logic [N-1:0]    r_t;
  logic [RW-1:0]   r_res;
  logic            r_carry;
  logic [IW-1:0]   r_idx;

  logic [31:0]     w_base;
  logic [CHUNK-1:0] w_s_chunk;
  logic [CHUNK-1:0] w_t_chunk;
  logic [CHUNK:0]  w_add;
  logic            w_last;
  logic            w_accept;
  logic [RW-1:0]   w_wmask;
  logic [RW-1:0]   w_wdata;
  logic            w_early;

  // chunk extraction and adder for the current index
  always_comb begin
    w_base    = 32'(r_idx) * 32'(CHUNK);
    w_s_chunk = CHUNK'(r_s >> w_base);
    w_t_chunk = CHUNK'(r_t >> w_base);
    w_add     = {1'b0, w_s_chunk} + {1'b0, w_t_chunk} + {{CHUNK{1'b0}}, r_carry};
    w_last    = (r_idx == IW'(NCH - 1));
    w_accept  = (r_state == S_IDLE) && bus.in_valid;
    // shifting in RW width drops chunk bits above N on the partial last chunk
    w_wmask   = RW'({CHUNK{1'b1}}) << w_base;
    w_wdata   = RW'(w_add[CHUNK-1:0]) << w_base;
  end

`ifdef CSA_RESOLVE_EARLY_EXIT_EN
  // nothing left to add above this chunk and no carry into it
  always_comb begin
    w_early = !w_add[CHUNK] && (((r_s | r_t) >> (w_base + 32'(CHUNK))) == '0);
  end
`else
  // fixed-latency build: never leave RUN early
  always_comb begin
    w_early = 1'b0;
  end
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.in_valid)        w_state_nxt = S_RUN;
      S_RUN:  if (w_last || w_early)   w_state_nxt = S_DONE;
      S_DONE: if (bus.out_ready)       w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.out_valid = (r_state == S_DONE);
    bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
    bus.sum       = r_res;
  end

  // operand capture and chunk-by-chunk result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= '0;
      r_t     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_s     <= bus.s_in;
      r_t     <= bus.t_in;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_res   <= (r_res & ~w_wmask) | w_wdata;
      // the carry-out lands in sum[N]; for a full last chunk it lies outside the write window
      if (w_last) r_res[N] <= w_add[LASTB];
      r_carry <= w_add[CHUNK];
      r_idx   <= r_idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_csa_resolve_seq.sv
module tb_csa_resolve_seq;
  localparam int N = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csa_resolve_seq_if #(.N(N)) bus4 ();
  csa_resolve_seq_if #(.N(N)) bus5 ();

  csa_resolve_seq #(.N(N), .CHUNK(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  csa_resolve_seq #(.N(N), .CHUNK(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));

  int n_pass = 0;
  int n_total = 0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Number of RUN cycles the stage needs for operands s,t at chunk width c.
  function automatic int exp_runs(input logic [11:0] s, input logic [11:0] t, input int c);
    int nch;
    nch = (N + c - 1) / c;
`ifdef CSA_RESOLVE_EARLY_EXIT_EN
    for (int k = 0; k < nch - 1; k++) begin
      int w;
      logic [11:0] m;
      logic [12:0] lo;
      w  = (k + 1) * c;
      m  = 12'((1 << w) - 1);
      lo = {1'b0, s & m} + {1'b0, t & m};
      if ((lo >> w) == 13'd0 && ((s | t) >> w) == 12'd0) return k + 1;
    end
`endif
    return nch;
  endfunction

  task automatic run4(input logic [11:0] s, input logic [11:0] t, input bit pulse, input int hold, input string name);
    logic [12:0] exp_sum;
    int lat, exp_lat;
    exp_sum = {1'b0, s} + {1'b0, t};
    exp_lat = exp_runs(s, t, 4) + 1;
    lat = 0;
    while (bus4.in_ready !== 1'b1 && lat < 50) begin step; lat++; end
    n_total++;
    if (bus4.in_ready !== 1'b1) $display("FAIL %s idle_ready got=%b want=1", name, bus4.in_ready);
    else n_pass++;
    bus4.s_in = s; bus4.t_in = t; bus4.in_valid = 1'b1;
    step;
    lat = 1;
    bus4.in_valid = 1'b0;
    while (bus4.out_valid !== 1'b1 && lat < 50) begin
      if (pulse) begin
        bus4.in_valid = 1'b1; bus4.s_in = 12'($urandom); bus4.t_in = 12'($urandom);
      end
      step;
      lat++;
    end
    n_total++;
    if (lat !== exp_lat) $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat);
    else n_pass++;
    n_total++;
    if (bus4.sum !== exp_sum || bus4.busy !== 1'b1 || bus4.in_ready !== 1'b0)
      $display("FAIL %s result sum=%h busy=%b rdy=%b want sum=%h busy=1 rdy=0",
               name, bus4.sum, bus4.busy, bus4.in_ready, exp_sum);
    else n_pass++;
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        bus4.in_valid = 1'b1; bus4.s_in = 12'($urandom); bus4.t_in = 12'($urandom);
      end
      step;
      n_total++;
      if (bus4.out_valid !== 1'b1 || bus4.sum !== exp_sum || bus4.in_ready !== 1'b0)
        $display("FAIL %s hold%0d vld=%b sum=%h rdy=%b want vld=1 sum=%h rdy=0",
                 name, i, bus4.out_valid, bus4.sum, bus4.in_ready, exp_sum);
      else n_pass++;
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    step;
    bus4.out_ready = 1'b0;
    n_total++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1 || bus4.busy !== 1'b0 || bus4.sum !== exp_sum)
      $display("FAIL %s release vld=%b rdy=%b busy=%b sum=%h want vld=0 rdy=1 busy=0 sum=%h",
               name, bus4.out_valid, bus4.in_ready, bus4.busy, bus4.sum, exp_sum);
    else n_pass++;
  endtask

  task automatic run5(input logic [11:0] s, input logic [11:0] t, input string name);
    logic [12:0] exp_sum;
    int lat, exp_lat;
    exp_sum = {1'b0, s} + {1'b0, t};
    exp_lat = exp_runs(s, t, 5) + 1;
    bus5.s_in = s; bus5.t_in = t; bus5.in_valid = 1'b1;
    step;
    lat = 1;
    bus5.in_valid = 1'b0;
    while (bus5.out_valid !== 1'b1 && lat < 50) begin step; lat++; end
    n_total++;
    if (lat !== exp_lat || bus5.sum !== exp_sum)
      $display("FAIL %s c5 lat=%0d sum=%h want lat=%0d sum=%h", name, lat, bus5.sum, exp_lat, exp_sum);
    else n_pass++;
    bus5.out_ready = 1'b1;
    step;
    bus5.out_ready = 1'b0;
    n_total++;
    if (bus5.in_ready !== 1'b1 || bus5.out_valid !== 1'b0)
      $display("FAIL %s c5_release rdy=%b vld=%b want rdy=1 vld=0", name, bus5.in_ready, bus5.out_valid);
    else n_pass++;
  endtask

  task automatic test_reset;
    bus4.in_valid = 1'b1; bus4.s_in = 12'hABC; bus4.t_in = 12'h123; bus4.out_ready = 1'b0;
    bus5.in_valid = 1'b0; bus5.s_in = '0; bus5.t_in = '0; bus5.out_ready = 1'b0;
    step;
    step;
    n_total++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.busy !== 1'b0 || bus4.sum !== 13'h0)
      $display("FAIL reset rdy=%b vld=%b busy=%b sum=%h want 1 0 0 0",
               bus4.in_ready, bus4.out_valid, bus4.busy, bus4.sum);
    else n_pass++;
    n_total++;
    if (bus5.in_ready !== 1'b1 || bus5.busy !== 1'b0 || bus5.sum !== 13'h0)
      $display("FAIL reset_c5 rdy=%b busy=%b sum=%h want 1 0 0", bus5.in_ready, bus5.busy, bus5.sum);
    else n_pass++;
    bus4.in_valid = 1'b0;
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_directed;
    run4(12'h0FF, 12'h001, 1'b0, 0, "carry_chain");
    run4(12'hFFF, 12'hFFF, 1'b0, 0, "all_ones");
    run4(12'h000, 12'h000, 1'b0, 0, "zeros");
    run4(12'h003, 12'h001, 1'b0, 0, "small");
  endtask

  task automatic test_backpressure;
    run4(12'h5A5, 12'h3C3, 1'b1, 10, "backpressure");
  endtask

  task automatic test_reset_mid_run;
    bus4.s_in = 12'hFFF; bus4.t_in = 12'hFFF; bus4.in_valid = 1'b1;
    step;
    bus4.in_valid = 1'b0;
    step;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.busy !== 1'b0 || bus4.sum !== 13'h0)
      $display("FAIL async_reset rdy=%b vld=%b busy=%b sum=%h want 1 0 0 0",
               bus4.in_ready, bus4.out_valid, bus4.busy, bus4.sum);
    else n_pass++;
    step;
    step;
    rst_n = 1'b1;
    step;
    run4(12'h123, 12'h321, 1'b0, 0, "after_reset");
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++)
      run4(12'($urandom), 12'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "random");
  endtask

  task automatic test_chunk5;
    run5(12'hC00, 12'h400, "c5_directed");
    run5(12'hFFF, 12'h001, "c5_carry");
    for (int i = 0; i < 10; i++) run5(12'($urandom), 12'($urandom), "c5_random");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid_run;
    test_random;
    test_chunk5;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
